// File: rtl/anita4_trigger_out_serializer.sv
// Serializes the 12 edge-detected L1 trigger bits to the TURF as start + data [+ parity] frames.
// Optional odd parity bit is compiled in with `define ANITA4_TRIG_PARITY_EN.
module anita4_trigger_out_serializer #(
  parameter int BIT_CYCLES = 4,
  parameter int GAP_CYCLES = 8,
  parameter int HOLDOFF    = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [11:0] mask_i,
  input  logic [1:0]  top_lcp_i,
  input  logic [1:0]  top_rcp_i,
  input  logic [1:0]  mid_lcp_i,
  input  logic [1:0]  mid_rcp_i,
  input  logic [1:0]  bot_lcp_i,
  input  logic [1:0]  bot_rcp_i,
  output logic        trig_o,
  output logic        busy_o,
  output logic [15:0] frame_count_o,
  output logic [7:0]  merge_count_o
);

`ifdef ANITA4_TRIG_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, GAP} state_t;
`endif

  localparam int CMAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HW   = $clog2(HOLDOFF + 1);

  state_t          state, state_n;
  logic [11:0]     d, in_r, hold_act, edges, pend, shift_reg, merged;
  logic [HW-1:0]   hold_cnt [12];
  logic [CW-1:0]   cyc_cnt;
  logic [3:0]      bit_cnt;
  logic [3:0]      merge_n;
  logic [8:0]      merge_sum;
  logic            load, bit_last, data_last, gap_last;
`ifdef ANITA4_TRIG_PARITY_EN
  logic            par_r;
`endif

  assign d         = {top_lcp_i, top_rcp_i, mid_lcp_i, mid_rcp_i, bot_lcp_i, bot_rcp_i};
  assign edges     = d & ~in_r & ~mask_i & ~hold_act & {12{enable_i}};
  assign load      = (state == IDLE) && (pend != '0);
  assign bit_last  = (cyc_cnt == CW'(BIT_CYCLES - 1));
  assign data_last = bit_last && (bit_cnt == 4'd11);
  assign gap_last  = (cyc_cnt == CW'(GAP_CYCLES - 1));
  // Edges landing in the load cycle start the next frame, so they never count as merges.
  assign merged    = edges & pend & {12{~load}};
  assign merge_sum = {1'b0, merge_count_o} + {5'd0, merge_n};

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    merge_n = '0;
    for (int i = 0; i < 12; i++) begin
      merge_n = merge_n + {3'b000, merged[i]};
    end
  end

  always_comb begin
    hold_act = '0;
    for (int i = 0; i < 12; i++) begin
      hold_act[i] = (hold_cnt[i] != '0);
    end
  end

  // NOTE: the holdoff array is small and must come up cleared, so it is reset like any register.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 12; i++) begin
      if (!rst_n_i)         hold_cnt[i] <= '0;
      else if (edges[i])    hold_cnt[i] <= HW'(HOLDOFF - 1);
      else if (hold_act[i]) hold_cnt[i] <= hold_cnt[i] - HW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (load)      state_n = START;
      START: if (bit_last)  state_n = DATA;
`ifdef ANITA4_TRIG_PARITY_EN
      DATA:  if (data_last) state_n = PAR;
      PAR:   if (bit_last)  state_n = GAP;
`else
      DATA:  if (data_last) state_n = GAP;
`endif
      GAP:   if (gap_last)  state_n = IDLE;
      default:              state_n = IDLE;
    endcase
  end

  always_comb begin
    trig_o = 1'b0;
    busy_o = (state != IDLE);
    case (state)
      START:   trig_o = 1'b1;
      DATA:    trig_o = shift_reg[11];
`ifdef ANITA4_TRIG_PARITY_EN
      PAR:     trig_o = par_r;
`endif
      default: trig_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      in_r          <= '0;
      pend          <= '0;
      shift_reg     <= '0;
      cyc_cnt       <= '0;
      bit_cnt       <= '0;
      frame_count_o <= '0;
      merge_count_o <= '0;
`ifdef ANITA4_TRIG_PARITY_EN
      par_r         <= 1'b0;
`endif
    end else begin
      in_r <= d;
      if (load) begin
        shift_reg <= pend;
        pend      <= edges;
        bit_cnt   <= '0;
`ifdef ANITA4_TRIG_PARITY_EN
        par_r     <= ~^pend;
`endif
      end else begin
        pend <= pend | edges;
        if (state == DATA && bit_last) begin
          shift_reg <= {shift_reg[10:0], 1'b0};
          bit_cnt   <= bit_cnt + 4'd1;
        end
      end
      if (state_n != state || (state == DATA && bit_last)) cyc_cnt <= '0;
      else if (state != IDLE)                              cyc_cnt <= cyc_cnt + CW'(1);
      if (state_n == GAP && state != GAP) frame_count_o <= frame_count_o + 16'd1;
      merge_count_o <= merge_sum[8] ? 8'hFF : merge_sum[7:0];
    end
  end

endmodule

// File: tb/tb_anita4_trigger_out_serializer.sv
// Directed self-checking bench for anita4_trigger_out_serializer; follows ANITA4_TRIG_PARITY_EN.
module tb_anita4_trigger_out_serializer;

  localparam int BIT_C  = 4;
  localparam int GAP_C  = 8;
  localparam int HOLD_C = 16;
`ifdef ANITA4_TRIG_PARITY_EN
  localparam int NB = 14;
`else
  localparam int NB = 13;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] mask;
  logic [1:0]  top_lcp, top_rcp, mid_lcp, mid_rcp, bot_lcp, bot_rcp;
  logic        trig, busy;
  logic [15:0] frame_count;
  logic [7:0]  merge_count;

  int checks   = 0;
  int failures = 0;

  anita4_trigger_out_serializer #(
    .BIT_CYCLES(BIT_C),
    .GAP_CYCLES(GAP_C),
    .HOLDOFF   (HOLD_C)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .mask_i       (mask),
    .top_lcp_i    (top_lcp),
    .top_rcp_i    (top_rcp),
    .mid_lcp_i    (mid_lcp),
    .mid_rcp_i    (mid_rcp),
    .bot_lcp_i    (bot_lcp),
    .bot_rcp_i    (bot_rcp),
    .trig_o       (trig),
    .busy_o       (busy),
    .frame_count_o(frame_count),
    .merge_count_o(merge_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [11:0] v);
    top_lcp = v[11:10];
    top_rcp = v[9:8];
    mid_lcp = v[7:6];
    mid_rcp = v[5:4];
    bot_lcp = v[3:2];
    bot_rcp = v[1:0];
  endtask

  // Entered 1 time unit after the edge that put the DUT in START; leaves it back in IDLE.
  // Pulses 'inj' on the inputs at frame cycles inj1 and inj2 (-1 = unused).
  task automatic expect_frame(input logic [11:0] data, input logic par, input logic [15:0] fc,
                              input int inj1, input int inj2, input logic [11:0] inj,
                              input string tag);
    int   k;
    logic exp_bit;
    k = 0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < BIT_C; c++) begin
        if (b == 0)       exp_bit = 1'b1;
        else if (b <= 12) exp_bit = data[12-b];
        else              exp_bit = par;
        check({tag, "_trig"}, {31'd0, trig}, {31'd0, exp_bit});
        if (k == inj1 || k == inj2) set_d(inj);
        else                        set_d('0);
        tick(1);
        k++;
      end
    end
    check({tag, "_frame_count"}, {16'd0, frame_count}, {16'd0, fc});
    for (int g = 0; g < GAP_C; g++) begin
      check({tag, "_gap_trig"}, {31'd0, trig}, 32'd0);
      check({tag, "_gap_busy"}, {31'd0, busy}, 32'd1);
      tick(1);
    end
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    mask   = '0;
    set_d('0);
    tick(3);
    check("reset_trig", {31'd0, trig}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_frame_count", {16'd0, frame_count}, 32'd0);
    check("reset_merge_count", {24'd0, merge_count}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single pulse on mid_rcp[1] = D[5]; line still idle one edge after capture.
    set_d(12'h020);
    tick(1);
    set_d('0);
    check("t1_latency_trig", {31'd0, trig}, 32'd0);
    check("t1_latency_busy", {31'd0, busy}, 32'd0);
    tick(1);
    check("t1_start_busy", {31'd0, busy}, 32'd1);
    expect_frame(12'h020, 1'b0, 16'd1, -1, -1, 12'h000, "t1");

    // top_lcp[0] (D[10]) and bot_rcp[0] (D[0]) together: one frame 12'h401.
    set_d(12'h401);
    tick(1);
    set_d('0);
    tick(1);
    expect_frame(12'h401, 1'b1, 16'd2, -1, -1, 12'h000, "t2");

    // D[0] arrives 5 clocks into frame 1 and rides frame 2.
    set_d(12'h020);
    tick(1);
    set_d('0);
    tick(1);
    expect_frame(12'h020, 1'b0, 16'd3, 5, -1, 12'h001, "t3f1");
    tick(1);
    check("t3_f2_start_busy", {31'd0, busy}, 32'd1);
    expect_frame(12'h001, 1'b0, 16'd4, -1, -1, 12'h000, "t3f2");

    // Second pulse 10 clocks after the first falls in holdoff: nothing further is sent.
    set_d(12'h020);
    tick(1);
    set_d('0);
    tick(1);
    expect_frame(12'h020, 1'b0, 16'd5, 8, -1, 12'h020, "t4a");
    tick(3);
    check("t4a_no_second_frame", {31'd0, busy}, 32'd0);
    check("t4a_merge_count", {24'd0, merge_count}, 32'd0);

    // Pulses 20 and 40 clocks after the first: the third merges into the pending bit.
    set_d(12'h020);
    tick(1);
    set_d('0);
    tick(1);
    expect_frame(12'h020, 1'b0, 16'd6, 18, 38, 12'h020, "t4b");
    check("t4b_merge_count", {24'd0, merge_count}, 32'd1);
    tick(1);
    check("t4c_start_busy", {31'd0, busy}, 32'd1);
    expect_frame(12'h020, 1'b0, 16'd7, -1, -1, 12'h000, "t4c");
    check("t4c_merge_count", {24'd0, merge_count}, 32'd1);

    // Fully masked, then disabled: no capture at all.
    mask = 12'hFFF;
    set_d(12'hFFF);
    tick(1);
    set_d('0);
    tick(3);
    check("t5_mask_trig", {31'd0, trig}, 32'd0);
    check("t5_mask_busy", {31'd0, busy}, 32'd0);
    mask = '0;
    tick(2);
    check("t5_mask_nothing_pending", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    set_d(12'hFFF);
    tick(1);
    set_d('0);
    tick(3);
    check("t5_disable_trig", {31'd0, trig}, 32'd0);
    check("t5_disable_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    tick(2);
    check("t5_disable_nothing_pending", {31'd0, busy}, 32'd0);
    check("t5_frame_count", {16'd0, frame_count}, 32'd7);

    // Reset in the middle of DATA.
    set_d(12'h008);
    tick(1);
    set_d('0);
    tick(1);
    check("t6_start_trig", {31'd0, trig}, 32'd1);
    tick(BIT_C + 2 * BIT_C);
    check("t6_in_data_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("t6_reset_trig", {31'd0, trig}, 32'd0);
    check("t6_reset_busy", {31'd0, busy}, 32'd0);
    check("t6_reset_frame_count", {16'd0, frame_count}, 32'd0);
    check("t6_reset_merge_count", {24'd0, merge_count}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("t6_after_reset_busy", {31'd0, busy}, 32'd0);
    check("t6_after_reset_trig", {31'd0, trig}, 32'd0);

    // Normal operation resumes after reset.
    set_d(12'h020);
    tick(1);
    set_d('0);
    tick(1);
    check("t7_start_busy", {31'd0, busy}, 32'd1);
    expect_frame(12'h020, 1'b0, 16'd1, -1, -1, 12'h000, "t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
